register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//  Multi-port successor to the base register file, with parametrised read and write port counts.
//  Adds per-byte write enables, deterministic write-port priority and optional same-cycle write forwarding.
//  Adds a sequenced clear engine that zeroes the array after reset or on request.
//  Sits in the decode/writeback path of wider-issue Mini-MIPS cores; register 0 remains hard-wired $zero.
// PARAMETERS
//  COUNT        32  number of registers; ADDR_WIDTH = $clog2(COUNT) (localparam)
//  BUS_WIDTH    32  register width in bits; must be a multiple of 8; BYTES = BUS_WIDTH/8 (localparam)
//  READ_PORTS   2   number of asynchronous read ports, >= 1
//  WRITE_PORTS  2   number of clocked write ports, >= 1
//  BYPASS       0   0: a read sees old data on a same-cycle write; 1: a read sees the data being written
// PORTS
//  clk         in   1                        rising-edge clock, single clock domain
//  rst_n       in   1                        synchronous, active-low reset
//  clear_req   in   1                        1-cycle pulse; sampled only in READY; starts an array clear
//  read_addr   in   READ_PORTS*ADDR_WIDTH    port p address = [p*ADDR_WIDTH +: ADDR_WIDTH]
//  data_out    out  READ_PORTS*BUS_WIDTH     port p data = [p*BUS_WIDTH +: BUS_WIDTH]
//  wr_en       in   WRITE_PORTS              per-port write enable
//  write_addr  in   WRITE_PORTS*ADDR_WIDTH   per-port write address, packed as read_addr
//  data_in     in   WRITE_PORTS*BUS_WIDTH    per-port write data
//  byte_en     in   WRITE_PORTS*BYTES        per-port byte mask; bit b covers bits [8b+7:8b]
//  ready       out  1                        1 = array valid and writes accepted
// BEHAVIOUR
//  FSM states: CLEAR and READY. A 1-cycle ready-to-clear delay is acceptable; no other state is allowed.
//  Reset:
//   - rst_n==0 at a clk edge: state<=CLEAR, clr_idx<=1, ready<=0. This holds for any state, including mid-clear.
//   - The array is not cleared by reset itself; clearing is done by the sequencer only.
//  CLEAR:
//   - Each cycle with rst_n==1: registers[clr_idx]<=0, clr_idx<=clr_idx+1.
//   - At clr_idx==COUNT-1 the register is written, then state<=READY and ready<=1 on the same edge.
//   - Total duration: COUNT-1 cycles after reset release (31 at default).
//   - All write ports and clear_req are ignored; every data_out port reads 0.
//  READY:
//   - clear_req==1 at an edge: state<=CLEAR, clr_idx<=1, ready<=0. Writes in that same cycle are still committed.
//  Writes (READY only):
//   - Committed on the rising edge. For each byte of each address, the highest-numbered port with wr_en=1 and byte_en[b]=1 wins.
//   - Bytes with no enabled writer keep their old value.
//   - wr_en=1 with byte_en=0 is a no-op.
//  Register 0:
//   - Writes to address 0 are discarded on every port.
//   - Reads of address 0 always return 0, in every mode and state.
//  Reads:
//   - Combinational, zero latency, no latching.
//   - BYPASS=0: returns the pre-edge contents (read-before-write).
//   - BYPASS=1: returns the merged value the array will hold after this edge (same per-byte priority); address 0 and the CLEAR state are excluded.
//  Width rules:
//   - Address values >= COUNT (non-power-of-2 COUNT): reads return 0, writes are discarded.
//   - No X may reach data_out after the first clear completes.
// TESTING
//  T1 reset: rst_n=0 for 2 cycles, then 1 -> ready=0 for exactly 31 cycles, then 1; every register reads 0.
//  T2 write/read: port0 writes r5=0xDEADBEEF, byte_en=0xF -> next cycle, both read ports at r5 return 0xDEADBEEF; r0 write of 0x1234 -> r0 reads 0.
//  T3 conflict: port0 r7=0x11111111 be=0xF, port1 r7=0x22222222 be=0x3, same cycle -> r7 reads 0x11112222.
//  T4 bypass: r9 holds 0xA5A5A5A5; write r9=0x5A5A5A5A be=0x1 while reading r9 -> BYPASS=0 reads 0xA5A5A5A5, BYPASS=1 reads 0xA5A5A55A; next cycle both read 0xA5A5A55A.
//  T5 reset mid-clear: assert rst_n=0 at clear cycle 10 for 1 cycle -> clear restarts at r1, ready rises 31 cycles after release.
//  T6 clear_req: fill r1..r31 with nonzero values, pulse clear_req together with a write to r3 -> ready=0 for 31 cycles, writes during CLEAR ignored, all registers then read 0.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port register file for wide-issue Mini-MIPS decode/writeback.
// Per-byte write priority (highest port wins), optional write forwarding, sequenced array clear.
module register_file_mp #(
    parameter  int COUNT       = 32,
    parameter  int BUS_WIDTH   = 32,
    parameter  int READ_PORTS  = 2,
    parameter  int WRITE_PORTS = 2,
    parameter  int BYPASS      = 0,
    localparam int ADDR_WIDTH  = $clog2(COUNT),
    localparam int BYTES       = BUS_WIDTH / 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear_req,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]  read_addr,
    output logic [READ_PORTS*BUS_WIDTH-1:0]   data_out,
    input  logic [WRITE_PORTS-1:0]            wr_en,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_addr,
    input  logic [WRITE_PORTS*BUS_WIDTH-1:0]  data_in,
    input  logic [WRITE_PORTS*BYTES-1:0]      byte_en,
    output logic                              ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(COUNT - 1);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_idx;
    logic [ADDR_WIDTH-1:0]   clr_idx_next;

    logic [BUS_WIDTH-1:0]    regs   [COUNT];
    logic [BUS_WIDTH-1:0]    merged [COUNT];
    logic [READ_PORTS-1:0]   rd_in_range;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= FIRST_IDX;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        case (state)
            CLEAR: begin
                clr_idx_next = clr_idx + 1'b1;
                if (clr_idx == LAST_IDX) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (clear_req) begin
                    state_next   = CLEAR;
                    clr_idx_next = FIRST_IDX;
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_idx_next = FIRST_IDX;
            end
        endcase
    end

    assign ready = (state == READY);

    // Value each register holds after this edge; later ports override earlier ones per byte.
    always_comb begin
        for (int unsigned r = 0; r < COUNT; r++) begin
            merged[r] = regs[r];
            if (r == 0) begin
                merged[r] = '0;
            end else begin
                for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
                    for (int unsigned b = 0; b < BYTES; b++) begin
                        if (wr_en[p] && byte_en[p*BYTES + b] &&
                            write_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
                            merged[r][8*b +: 8] = data_in[p*BUS_WIDTH + 8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                regs[clr_idx] <= '0;
            end else begin
                for (int unsigned r = 0; r < COUNT; r++) begin
                    regs[r] <= merged[r];
                end
            end
        end
    end

    generate
        if (COUNT == (1 << ADDR_WIDTH)) begin : g_full_range
            assign rd_in_range = '1;
        end else begin : g_partial_range
            for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd_range
                assign rd_in_range[p] =
                    ({1'b0, read_addr[p*ADDR_WIDTH +: ADDR_WIDTH]} < (ADDR_WIDTH + 1)'(COUNT));
            end
        end
    endgenerate

    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        data_out = '0;
        ra       = '0;
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            ra = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            if (state == READY && ra != '0 && rd_in_range[p]) begin
                data_out[p*BUS_WIDTH +: BUS_WIDTH] = (BYPASS != 0) ? merged[ra] : regs[ra];
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench: one DUT per BYPASS mode, shared stimulus, spec-level reference model.
module tb_register_file_mp;

    localparam int COUNT = 32;
    localparam int BW    = 32;
    localparam int RP    = 2;
    localparam int WP    = 2;
    localparam int AW    = 5;
    localparam int NB    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 clear_req;
    logic [RP*AW-1:0]     read_addr;
    logic [WP-1:0]        wr_en;
    logic [WP*AW-1:0]     write_addr;
    logic [WP*BW-1:0]     data_in;
    logic [WP*NB-1:0]     byte_en;
    logic [RP*BW-1:0]     dout0;
    logic [RP*BW-1:0]     dout1;
    logic                 ready0;
    logic                 ready1;

    register_file_mp #(.COUNT(COUNT), .BUS_WIDTH(BW), .READ_PORTS(RP),
                       .WRITE_PORTS(WP), .BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .read_addr(read_addr),
        .data_out(dout0), .wr_en(wr_en), .write_addr(write_addr), .data_in(data_in),
        .byte_en(byte_en), .ready(ready0));

    register_file_mp #(.COUNT(COUNT), .BUS_WIDTH(BW), .READ_PORTS(RP),
                       .WRITE_PORTS(WP), .BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .read_addr(read_addr),
        .data_out(dout1), .wr_en(wr_en), .write_addr(write_addr), .data_in(data_in),
        .byte_en(byte_en), .ready(ready1));

    // Stimulus for the next cycle, applied to the DUTs at the falling edge.
    logic          s_rst_n;
    logic          s_clear_req;
    logic [AW-1:0] s_raddr [RP];
    logic          s_we    [WP];
    logic [AW-1:0] s_waddr [WP];
    logic [BW-1:0] s_wdata [WP];
    logic [NB-1:0] s_be    [WP];

    // Optional hard-coded expectation for this cycle (all ports of each DUT).
    bit            pin_en;
    logic [BW-1:0] pin0;
    logic [BW-1:0] pin1;

    // Reference model: architectural contents plus remaining clear cycles.
    logic [BW-1:0] m [COUNT];
    bit            clearing;
    int            left;

    typedef struct {
        int            id;
        logic          rdy;
        logic [BW-1:0] d0 [RP];
        logic [BW-1:0] d1 [RP];
    } exp_t;
    exp_t q[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] after_write(input int a);
        logic [BW-1:0] v;
        if (a == 0) return '0;
        v = m[a];
        for (int p = 0; p < WP; p++)
            for (int b = 0; b < NB; b++)
                if (s_we[p] && s_be[p][b] && int'(s_waddr[p]) == a)
                    v[8*b +: 8] = s_wdata[p][8*b +: 8];
        return v;
    endfunction

    task automatic start_clear();
        clearing = 1'b1;
        left     = COUNT - 1;
        for (int r = 0; r < COUNT; r++) m[r] = '0;
    endtask

    task automatic step();
        exp_t          e;
        logic [BW-1:0] nxt [COUNT];
        @(negedge clk);
        rst_n     = s_rst_n;
        clear_req = s_clear_req;
        for (int p = 0; p < RP; p++) read_addr[p*AW +: AW] = s_raddr[p];
        for (int p = 0; p < WP; p++) begin
            wr_en[p]               = s_we[p];
            write_addr[p*AW +: AW] = s_waddr[p];
            data_in[p*BW +: BW]    = s_wdata[p];
            byte_en[p*NB +: NB]    = s_be[p];
        end
        e.id  = cyc;
        e.rdy = !clearing;
        for (int p = 0; p < RP; p++) begin
            if (clearing || s_raddr[p] == '0) begin
                e.d0[p] = '0;
                e.d1[p] = '0;
            end else begin
                e.d0[p] = m[s_raddr[p]];
                e.d1[p] = after_write(int'(s_raddr[p]));
            end
        end
        q.push_back(e);
        if (pin_en) begin
            #3;
            for (int p = 0; p < RP; p++) begin
                chk($sformatf("pin_bp0_p%0d_cyc%0d", p, cyc), dout0[p*BW +: BW], pin0);
                chk($sformatf("pin_bp1_p%0d_cyc%0d", p, cyc), dout1[p*BW +: BW], pin1);
            end
            pin_en = 1'b0;
        end
        @(posedge clk);
        cyc++;
        if (!s_rst_n) begin
            start_clear();
        end else if (clearing) begin
            left--;
            if (left == 0) clearing = 1'b0;
        end else begin
            for (int r = 0; r < COUNT; r++) nxt[r] = after_write(r);
            for (int r = 0; r < COUNT; r++) m[r] = nxt[r];
            if (s_clear_req) start_clear();
        end
    endtask

    task automatic idle();
        s_rst_n     = 1'b1;
        s_clear_req = 1'b0;
        for (int p = 0; p < WP; p++) begin
            s_we[p] = 1'b0; s_waddr[p] = '0; s_wdata[p] = '0; s_be[p] = '0;
        end
    endtask

    task automatic rand_writes();
        for (int p = 0; p < WP; p++) begin
            s_we[p]    = 1'($urandom_range(0, 1));
            s_waddr[p] = AW'($urandom_range(0, COUNT - 1));
            s_wdata[p] = $urandom;
            s_be[p]    = NB'($urandom_range(0, 15));
        end
        for (int p = 0; p < RP; p++) s_raddr[p] = AW'($urandom_range(0, COUNT - 1));
    endtask

    task automatic read_all();
        idle();
        for (int r = 0; r < COUNT / 2; r++) begin
            s_raddr[0] = AW'(r);
            s_raddr[1] = AW'(r + COUNT / 2);
            step();
        end
    endtask

    task automatic write1(input int a, input logic [BW-1:0] d, input logic [NB-1:0] be);
        idle();
        s_we[0] = 1'b1; s_waddr[0] = AW'(a); s_wdata[0] = d; s_be[0] = be;
    endtask

    task automatic pin(input logic [BW-1:0] a, input logic [BW-1:0] b);
        pin_en = 1'b1; pin0 = a; pin1 = b;
    endtask

    // Monitor: every cycle the read data and ready are valid; compare against queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk($sformatf("ready_bp0_cyc%0d", e.id), {31'b0, ready0}, {31'b0, e.rdy});
                chk($sformatf("ready_bp1_cyc%0d", e.id), {31'b0, ready1}, {31'b0, e.rdy});
                for (int p = 0; p < RP; p++) begin
                    chk($sformatf("rd_bp0_p%0d_cyc%0d", p, e.id), dout0[p*BW +: BW], e.d0[p]);
                    chk($sformatf("rd_bp1_p%0d_cyc%0d", p, e.id), dout1[p*BW +: BW], e.d1[p]);
                end
            end
        end
    end

    initial begin
        pin_en = 1'b0;
        idle();
        for (int p = 0; p < RP; p++) s_raddr[p] = '0;
        rst_n = 1'b0; clear_req = 1'b0; read_addr = '0;
        wr_en = '0; write_addr = '0; data_in = '0; byte_en = '0;

        // T1: two reset cycles, 31-cycle clear, everything reads 0.
        @(posedge clk);
        start_clear();
        s_rst_n = 1'b0;
        step();
        idle();
        repeat (COUNT - 1) begin
            for (int p = 0; p < RP; p++) s_raddr[p] = AW'($urandom_range(0, COUNT - 1));
            step();
        end
        read_all();

        // T2: basic write/read and r0 hard-wiring.
        write1(5, 32'hDEADBEEF, 4'hF); step();
        idle(); s_raddr[0] = 5; s_raddr[1] = 5; pin(32'hDEADBEEF, 32'hDEADBEEF); step();
        write1(0, 32'h00001234, 4'hF); s_raddr[0] = 0; s_raddr[1] = 0; pin('0, '0); step();
        idle(); pin('0, '0); step();

        // T3: same-address conflict, port1 wins the bytes it enables.
        idle();
        s_we[0] = 1; s_waddr[0] = 7; s_wdata[0] = 32'h11111111; s_be[0] = 4'hF;
        s_we[1] = 1; s_waddr[1] = 7; s_wdata[1] = 32'h22222222; s_be[1] = 4'h3;
        step();
        idle(); s_raddr[0] = 7; s_raddr[1] = 7; pin(32'h11112222, 32'h11112222); step();

        // T4: forwarding differs only on the write cycle; byte_en=0 is a no-op.
        write1(9, 32'hA5A5A5A5, 4'hF); step();
        write1(9, 32'h5A5A5A5A, 4'h1); s_raddr[0] = 9; s_raddr[1] = 9;
        pin(32'hA5A5A5A5, 32'hA5A5A55A); step();
        write1(9, 32'hFFFFFFFF, 4'h0); s_raddr[0] = 9; s_raddr[1] = 9;
        pin(32'hA5A5A55A, 32'hA5A5A55A); step();

        // T5: reset in the middle of a clear restarts the full sequence.
        idle(); s_rst_n = 1'b0; step();
        idle(); repeat (10) step();
        s_rst_n = 1'b0; step();
        idle();
        repeat (COUNT - 1) begin rand_writes(); step(); end
        read_all();

        // T6: fill, clear_req with a concurrent write, writes ignored during CLEAR.
        for (int r = 1; r < COUNT; r++) begin
            write1(r, $urandom | 32'h1, 4'hF);
            s_raddr[0] = AW'(r - 1); s_raddr[1] = AW'(r);
            step();
        end
        write1(3, 32'hCAFEF00D, 4'hF); s_clear_req = 1'b1; s_raddr[0] = 3; s_raddr[1] = 3; step();
        idle();
        repeat (COUNT - 1) begin rand_writes(); s_clear_req = 1'($urandom_range(0, 1)); step(); end
        read_all();

        // Random traffic with occasional clears and resets.
        repeat (400) begin
            idle();
            rand_writes();
            s_clear_req = ($urandom_range(0, 49) == 0);
            s_rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        idle();
        repeat (COUNT) step();
        read_all();

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #3;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
